spi_rom_responder: RTL and testbench

- SPI responder (device side) for the team's ROM-read link. It answers the SPI master's 32-bit read request, which is an 8-bit command followed by a 24-bit address.
- It fetches the addressed 32-bit word from an on-chip memory port and shifts it back on MISO, LSB first.
- Used as the flash model in system sims and as the boot-image server in FPGA loopback builds.
- SCL/MOSI are oversampled in clk; clk must be >= 8x the master's SCL bit rate.

---
 rtl/spi_rom_responder.sv | 177 +++++++++++++++++
 tb/tb_spi_rom_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rom_responder.sv
// SPI device-side responder: receives {cmd, addr} on MOSI, fetches one 32-bit word from a
// memory port and returns it on MISO, LSB first. SCL/MOSI are oversampled in clk.
module spi_rom_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDLE_CYCLES = 64,
  parameter logic [7:0]  READ_CMD    = 8'h0B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        mosi,
  output logic        miso,
  output logic [23:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy,
  output logic        cmd_err,
  output logic        late_err
);

  localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StRx, StFetch, StTx, StDiscard} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   scl_q, scl_d;
  logic [IdleW-1:0]       idle_cnt_q, idle_cnt_d;
  // Holds the first 31 request bits; the 32nd completes the word combinationally.
  logic [30:0]            rx_sr_q, rx_sr_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic [31:0]            tx_sr_q, tx_sr_d;
  logic                   tx_skip_q, tx_skip_d;
  logic                   miso_q, miso_d;
  logic [23:0]            mem_addr_q, mem_addr_d;
  logic                   mem_req_q, mem_req_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   late_err_q, late_err_d;

  logic        scl_s, mosi_s, rise, fall, idle_hit;
  logic [31:0] rx_word;

  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    scl_s       = scl_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    scl_d       = scl_s;
    rise        = scl_s & ~scl_q;
    fall        = ~scl_s & scl_q;
    rx_word     = {rx_sr_q, mosi_s};

    if (scl_s) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IdleW'(IDLE_CYCLES)) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + IdleW'(1);
    end
    idle_hit = (idle_cnt_d == IdleW'(IDLE_CYCLES));
  end

  always_comb begin
    state_d    = state_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    tx_skip_d  = tx_skip_q;
    miso_d     = miso_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = 1'b0;
    cmd_err_d  = 1'b0;
    late_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          rx_sr_d   = rx_word[30:0];
          bit_cnt_d = 6'd1;
          state_d   = StRx;
        end
      end
      StRx: begin
        if (rise) begin
          rx_sr_d   = rx_word[30:0];
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd31) begin
            if (rx_word[31:24] == READ_CMD) begin
              mem_addr_d = rx_word[23:0];
              mem_req_d  = 1'b1;
              state_d    = StFetch;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = StDiscard;
            end
          end
        end
      end
      StFetch: begin
        if (mem_rvalid) begin
          tx_sr_d   = mem_rdata;
          miso_d    = mem_rdata[0];
          bit_cnt_d = '0;
          // A fall in this same cycle is the end of the 32nd bit and is already consumed.
          tx_skip_d = ~fall;
          state_d   = StTx;
        end else if (fall) begin
          late_err_d = 1'b1;
          state_d    = StDiscard;
        end
      end
      StTx: begin
        if (fall) begin
          if (tx_skip_q) begin
            tx_skip_d = 1'b0;
          end else if (bit_cnt_q != 6'd31) begin
            tx_sr_d   = tx_sr_q >> 1;
            miso_d    = tx_sr_q[1];
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StDiscard: miso_d = 1'b0;
      default:   state_d = StIdle;
    endcase

    if (idle_hit && (state_q != StIdle)) begin
      state_d   = StIdle;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      scl_sync_q  <= '0;
      mosi_sync_q <= '0;
      scl_q       <= 1'b0;
      idle_cnt_q  <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      tx_skip_q   <= 1'b0;
      miso_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      late_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      mosi_sync_q <= mosi_sync_d;
      scl_q       <= scl_d;
      idle_cnt_q  <= idle_cnt_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      tx_skip_q   <= tx_skip_d;
      miso_q      <= miso_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      cmd_err_q   <= cmd_err_d;
      late_err_q  <= late_err_d;
    end
  end

  assign miso     = miso_q;
  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign cmd_err  = cmd_err_q;
  assign late_err = late_err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_rom_responder.sv
// Bench for spi_rom_responder: an SPI master task, a latency-programmable memory and a
// frame-level reference model (expected word or zero, expected pulse counts).
module tb_spi_rom_responder;

  localparam int H = 8;  // SCL half period in clk cycles

  logic        clk = 1'b0;
  logic        rst, scl, mosi, miso, mem_req, mem_rvalid, busy, cmd_err, late_err;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;
  int mem_lat     = 2;
  int lat_cnt     = 0;
  int req_cnt = 0, cmd_err_cnt = 0, late_err_cnt = 0, miso_hi_cnt = 0;

  spi_rom_responder #(
    .SYNC_STAGES(2),
    .IDLE_CYCLES(64),
    .READ_CMD   (8'h0B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .mosi      (mosi),
    .miso      (miso),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .late_err  (late_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [23:0] a);
    if (a == 24'h000012) return 32'h0123_4567;
    return {a[7:0] ^ 8'hA5, a[23:16], a[15:8] ^ 8'h3C, a[7:0] + 8'h11};
  endfunction

  // Memory model and pulse monitors, all evaluated away from the active edge.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt = lat_cnt - 1;
      if (lat_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rom_fn(mem_addr);
      end
    end
    if (mem_req) begin
      lat_cnt = mem_lat;
      req_cnt++;
    end
    if (cmd_err)  cmd_err_cnt++;
    if (late_err) late_err_cnt++;
    if (miso)     miso_hi_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: npulses SCL pulses; first 32 carry req MSB first, later ones capture MISO on rise.
  task automatic spi_xfer(input logic [31:0] req, input int npulses, output logic [31:0] rx);
    rx = '0;
    for (int p = 0; p < npulses; p++) begin
      mosi = (p < 32) ? req[31-p] : 1'b0;
      repeat (H) @(negedge clk);
      if (p >= 32) rx[p-32] = miso;
      scl = 1'b1;
      repeat (H) @(negedge clk);
      scl = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b0; mosi = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({miso, busy, mem_req, cmd_err, late_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 00000", {miso, busy, mem_req, cmd_err, late_err});
    end
    vectors++;
    if (mem_addr !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 000000", mem_addr);
    end
  endtask

  task automatic test_read_frame();
    logic [31:0] rx;
    int r0, c0, l0;
    r0 = req_cnt; c0 = cmd_err_cnt; l0 = late_err_cnt;
    mem_lat = 2;
    spi_xfer({8'h0B, 24'h000012}, 64, rx);
    vectors++;
    if (rx !== 32'h0123_4567) begin
      miscompares++;
      $display("FAIL read_data: got %h want 01234567", rx);
    end
    idle(60);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL read_busy_held: got %b want 1", busy);
    end
    idle(10);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_busy_fall: got %b want 0", busy);
    end
    vectors++;
    if (mem_addr !== 24'h000012) begin
      miscompares++;
      $display("FAIL read_addr: got %h want 000012", mem_addr);
    end
    vectors++;
    if ({req_cnt - r0, cmd_err_cnt - c0, late_err_cnt - l0} !== {32'd1, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL read_pulses: got req=%0d cmd_err=%0d late_err=%0d want 1 0 0",
               req_cnt - r0, cmd_err_cnt - c0, late_err_cnt - l0);
    end
  endtask

  // Reference model: the word comes back only for READ_CMD with in-time memory.
  task automatic good_frame(input string name, input logic [23:0] addr);
    logic [31:0] rx;
    int r0;
    r0 = req_cnt;
    spi_xfer({8'h0B, addr}, 64, rx);
    idle(80);
    vectors++;
    if (rx !== rom_fn(addr) || mem_addr !== addr || req_cnt - r0 != 1) begin
      miscompares++;
      $display("FAIL %s: got data=%h addr=%h reqs=%0d want data=%h addr=%h reqs=1",
               name, rx, mem_addr, req_cnt - r0, rom_fn(addr), addr);
    end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] rx;
    int r0, c0, m0;
    r0 = req_cnt; c0 = cmd_err_cnt; m0 = miso_hi_cnt;
    spi_xfer({8'h03, 24'hABCDEF}, 64, rx);
    idle(80);
    vectors++;
    if (cmd_err_cnt - c0 != 1 || req_cnt - r0 != 0) begin
      miscompares++;
      $display("FAIL bad_cmd_pulses: got cmd_err=%0d req=%0d want 1 0",
               cmd_err_cnt - c0, req_cnt - r0);
    end
    vectors++;
    if (rx !== 32'h0 || miso_hi_cnt != m0) begin
      miscompares++;
      $display("FAIL bad_cmd_miso: got rx=%h hi_cycles=%0d want 0 0", rx, miso_hi_cnt - m0);
    end
    good_frame("bad_cmd_recover", 24'h00_5A5A);
  endtask

  task automatic test_slow_mem();
    logic [31:0] rx;
    int r0, l0, m0;
    r0 = req_cnt; l0 = late_err_cnt; m0 = miso_hi_cnt;
    mem_lat = 20;
    spi_xfer({8'h0B, 24'h000777}, 64, rx);
    idle(80);
    mem_lat = 2;
    vectors++;
    if (late_err_cnt - l0 != 1 || req_cnt - r0 != 1) begin
      miscompares++;
      $display("FAIL slow_pulses: got late_err=%0d req=%0d want 1 1",
               late_err_cnt - l0, req_cnt - r0);
    end
    vectors++;
    if (rx !== 32'h0 || miso_hi_cnt != m0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL slow_miso: got rx=%h hi_cycles=%0d busy=%b want 0 0 0",
               rx, miso_hi_cnt - m0, busy);
    end
    good_frame("slow_recover", 24'h000778);
  endtask

  task automatic test_abort();
    logic [31:0] rx;
    int r0, c0;
    r0 = req_cnt; c0 = cmd_err_cnt;
    spi_xfer($urandom, 13, rx);
    idle(80);
    vectors++;
    if (busy !== 1'b0 || req_cnt != r0 || cmd_err_cnt != c0) begin
      miscompares++;
      $display("FAIL abort: got busy=%b req=%0d cmd_err=%0d want 0 0 0",
               busy, req_cnt - r0, cmd_err_cnt - c0);
    end
    good_frame("abort_recover_ffffff", 24'hFFFFFF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rx, w;
    logic [23:0] addr;
    addr = 24'($urandom);
    w    = rom_fn(addr);
    spi_xfer({8'h0B, addr}, 42, rx);
    idle(5);
    vectors++;
    if (busy !== 1'b1 || miso !== w[10] || rx[9:0] !== w[9:0]) begin
      miscompares++;
      $display("FAIL mid_tx: got busy=%b miso=%b rx=%h want 1 %b %h",
               busy, miso, rx[9:0], w[10], w[9:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (miso !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got miso=%b busy=%b want 0 0", miso, busy);
    end
    idle(80);
    good_frame("reset_recover", 24'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx0, rx1, w0, w1;
    int r0;
    w0 = rom_fn(24'h000000);
    w1 = rom_fn(24'h000001);
    r0 = req_cnt;
    spi_xfer({8'h0B, 24'h000000}, 64, rx0);
    idle(64 - H);
    spi_xfer({8'h0B, 24'h000001}, 64, rx1);
    idle(80);
    vectors++;
    if (rx0 !== w0 || rx1 !== w1 || req_cnt - r0 != 2) begin
      miscompares++;
      $display("FAIL b2b_gap64: got %h %h reqs=%0d want %h %h reqs=2",
               rx0, rx1, req_cnt - r0, w0, w1);
    end
    // One cycle short of the timeout: the second request lands in TX of the first frame.
    r0 = req_cnt;
    spi_xfer({8'h0B, 24'h000000}, 64, rx0);
    idle(63 - H);
    spi_xfer({8'h0B, 24'h000001}, 64, rx1);
    idle(80);
    vectors++;
    if (rx0 !== w0 || rx1 !== {32{w0[31]}} || req_cnt - r0 != 1) begin
      miscompares++;
      $display("FAIL b2b_gap63: got %h %h reqs=%0d want %h %h reqs=1",
               rx0, rx1, req_cnt - r0, w0, {32{w0[31]}});
    end
  endtask

  task automatic test_random();
    logic [31:0] rx, exp_rx;
    logic [23:0] addr;
    logic [7:0]  cmd;
    int r0, c0, l0, exp_req;
    for (int i = 0; i < 8; i++) begin
      addr    = 24'($urandom);
      cmd     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0B;
      mem_lat = $urandom_range(1, 4);
      r0 = req_cnt; c0 = cmd_err_cnt; l0 = late_err_cnt;
      spi_xfer({cmd, addr}, 64, rx);
      idle(80);
      exp_req = (cmd == 8'h0B) ? 1 : 0;
      exp_rx  = (cmd == 8'h0B) ? rom_fn(addr) : 32'h0;
      vectors++;
      if (rx !== exp_rx || req_cnt - r0 != exp_req || cmd_err_cnt - c0 != 1 - exp_req ||
          late_err_cnt != l0) begin
        miscompares++;
        $display("FAIL random_%0d cmd=%h addr=%h lat=%0d: got %h req=%0d cerr=%0d lerr=%0d want %h %0d %0d 0",
                 i, cmd, addr, mem_lat, rx, req_cnt - r0, cmd_err_cnt - c0, late_err_cnt - l0,
                 exp_rx, exp_req, 1 - exp_req);
      end
    end
    mem_lat = 2;
  endtask

  initial begin
    test_reset();
    test_read_frame();
    test_bad_cmd();
    test_slow_mem();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
